// File: rtl/updown_count_pkg.sv
// Shared types and constants for the bounded up/down counter controller.
package updown_count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_core.sv
// Load-and-step counter: synchronous load has priority over stepping.
module updown_count_core
  import updown_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = init;
    end else if (en) begin
      q_d = (dir == DIR_DOWN) ? (q_q - ONE) : (q_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/updown_count_ctrl.sv
// Sequencing controller: captures bound/direction, steps the counter core on
// qualified ticks until the terminal count, then pulses done or auto-reloads.
module updown_count_ctrl
  import updown_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             tick,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_r_q, dir_r_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic             core_ld;
  logic [WIDTH-1:0] core_init;
  logic             core_en;
  logic             at_target;

  assign at_target = (q == target_q);

  always_comb begin
    state_d   = state_q;
    dir_r_d   = dir_r_q;
    target_d  = target_q;
    core_ld   = 1'b0;
    core_init = '0;
    core_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The counter is initialised even when stop aborts the load.
        dir_r_d   = dir;
        core_ld   = 1'b1;
        core_init = (dir == DIR_DOWN) ? load_val : '0;
        target_d  = (dir == DIR_DOWN) ? '0 : load_val;
        state_d   = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (at_target) begin
          state_d = ST_DONE;
        end else if (tick) begin
          core_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (auto_reload) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dir_r_q  <= DIR_UP;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_r_q  <= dir_r_d;
      target_q <= target_d;
    end
  end

  updown_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .ld  (core_ld),
    .init(core_init),
    .en  (core_en),
    .dir (dir_r_q),
    .q   (q)
  );

  assign busy = (state_q != ST_IDLE);
  assign tc   = (state_q == ST_RUN) && at_target;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl (WIDTH=4) with hand-computed expectations.
module tb_updown_count_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         dir;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic         tick;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;

  int compared   = 0;
  int mismatched = 0;

  updown_count_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .tick       (tick),
    .q          (q),
    .busy       (busy),
    .tc         (tc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int eq, input int eb, input int et, input int ed);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".tc"},   32'(tc),   32'(et));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_up[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4};

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
    load_val = '0; auto_reload = 1'b0; tick = 1'b0;

    // Reset state
    step(); step();
    chk_out("reset", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk_out("idle_after_reset", 0, 0, 0, 0);

    // Down count, load_val=3, tick held
    start = 1'b1; dir = 1'b1; load_val = 4'd3; tick = 1'b1;
    step();
    start = 1'b0;
    chk_out("dn3_load", 0, 1, 0, 0);
    step(); chk_out("dn3_e1", 3, 1, 0, 0);
    step(); chk_out("dn3_e2", 2, 1, 0, 0);
    step(); chk_out("dn3_e3", 1, 1, 0, 0);
    step(); chk_out("dn3_e4", 0, 1, 1, 0);
    step(); chk_out("dn3_e5_done", 0, 1, 0, 1);
    step(); chk_out("dn3_e6_idle", 0, 0, 0, 0);
    step(); chk_out("dn3_e7_hold", 0, 0, 0, 0);

    // Up count, load_val=4, tick toggling; mid-run load_val/dir change and start pulse ignored
    start = 1'b1; dir = 1'b0; load_val = 4'd4; tick = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick  = (k % 2 == 1);
      start = (k == 4);
      if (k == 3) begin
        load_val = 4'd1;
        dir      = 1'b1;
      end
      step();
      chk($sformatf("up4_e%0d.q", k), 32'(q), 32'(exp_up[k]));
      chk($sformatf("up4_e%0d.tc", k), 32'(tc), (k == 9) ? 32'd1 : 32'd0);
    end
    start = 1'b0; tick = 1'b1;
    step(); chk_out("up4_done", 4, 1, 0, 1);
    step(); chk_out("up4_idle", 4, 0, 0, 0);

    // load_val=0, up then down
    for (int d = 0; d < 2; d++) begin
      start = 1'b1; dir = d[0]; load_val = 4'd0; tick = 1'b1;
      step();
      start = 1'b0;
      step(); chk_out($sformatf("zero_d%0d_run", d), 0, 1, 1, 0);
      step(); chk_out($sformatf("zero_d%0d_done", d), 0, 1, 0, 1);
      step(); chk_out($sformatf("zero_d%0d_idle", d), 0, 0, 0, 0);
    end

    // Full-range down count from 15, no wrap
    start = 1'b1; dir = 1'b1; load_val = 4'd15; tick = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("dn15_e%0d.q", k), 32'(q), 32'(16 - k));
    end
    step(); chk_out("dn15_done", 0, 1, 0, 1);
    step(); chk_out("dn15_idle", 0, 0, 0, 0);

    // Auto-reload, down, load_val=2; stop in DONE ends it
    start = 1'b1; dir = 1'b1; load_val = 4'd2; tick = 1'b1; auto_reload = 1'b1;
    step();
    start = 1'b0;
    step(); chk_out("ar_p1_e1", 2, 1, 0, 0);
    step(); chk_out("ar_p1_e2", 1, 1, 0, 0);
    step(); chk_out("ar_p1_e3", 0, 1, 1, 0);
    step(); chk_out("ar_p1_done", 0, 1, 0, 1);
    step(); chk_out("ar_reload", 0, 1, 0, 0);
    step(); chk_out("ar_p2_e1", 2, 1, 0, 0);
    step(); chk_out("ar_p2_e2", 1, 1, 0, 0);
    step(); chk_out("ar_p2_e3", 0, 1, 1, 0);
    step(); chk_out("ar_p2_done", 0, 1, 0, 1);
    stop = 1'b1;
    step(); chk_out("ar_stop_idle", 0, 0, 0, 0);
    stop = 1'b0;
    step(); chk_out("ar_no_reload", 0, 0, 0, 0);
    auto_reload = 1'b0;

    // start+stop together in IDLE -> LOAD; stop in RUN at q=1
    start = 1'b1; stop = 1'b1; dir = 1'b1; load_val = 4'd3; tick = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk_out("ss_load", 0, 1, 0, 0);
    step(); chk_out("ss_e1", 3, 1, 0, 0);
    step(); chk_out("ss_e2", 2, 1, 0, 0);
    step(); chk_out("ss_e3", 1, 1, 0, 0);
    stop = 1'b1;
    step(); chk_out("ss_stop", 1, 0, 0, 0);
    stop = 1'b0;
    step(); chk_out("ss_hold", 1, 0, 0, 0);

    // stop during LOAD: back to IDLE with q still loaded
    start = 1'b1; dir = 1'b1; load_val = 4'd6;
    step();
    start = 1'b0; stop = 1'b1;
    step(); chk_out("ldstop", 6, 0, 0, 0);
    stop = 1'b0;

    // Asynchronous reset mid-RUN, down from 9
    start = 1'b1; dir = 1'b1; load_val = 4'd9; tick = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk_out("rstmid_pre", 5, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("rstmid_async", 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step(); chk_out("rstmid_post1", 0, 0, 0, 0);
    step(); chk_out("rstmid_post2", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
